// File: rtl/div_iterative_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Radix-2 restoring division retires one
// quotient bit per cycle; divide-by-zero and signed overflow resolve in one cycle.
module div_iterative_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic            ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            is_rem_q, is_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;

    logic            is_signed;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            overflow;
    logic [XLEN:0]   rem_shift, trial;
    logic [XLEN-1:0] quo_next, rem_next;

    assign is_signed = ~div_op[0];
    assign mag_a     = (is_signed && rdata1[XLEN-1]) ? -rdata1 : rdata1;
    assign mag_b     = (is_signed && rdata2[XLEN-1]) ? -rdata2 : rdata2;
    assign overflow  = is_signed && (rdata1 == INT_MIN) && (rdata2 == '1);

    // One restoring step: shift {rem,quo} left, subtract the divisor, keep it if non-negative.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign quo_next  = {quo_q[XLEN-2:0], ~trial[XLEN]};
    assign rem_next  = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case leaves a latch.
        state_d  = state_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    is_rem_d = div_op[1];
                    qneg_d   = is_signed & (rdata1[XLEN-1] ^ rdata2[XLEN-1]);
                    rneg_d   = is_signed & rdata1[XLEN-1];
                    dvs_d    = mag_b;
                    if (rdata2 == '0) begin
                        result_d = div_op[1] ? rdata1 : '1;
                        state_d  = DONE;
                    end else if (overflow) begin
                        result_d = div_op[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = mag_a;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    quo_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        result_d = is_rem_q ? (rneg_q ? -rem_next : rem_next)
                                            : (qneg_q ? -quo_next : quo_next);
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst) begin
            state_q  <= IDLE;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_iterative_unit.sv
// Directed bench for div_iterative_unit: latency, results, corner cases, abort,
// reset and back-to-back operation.
module tb_div_iterative_unit;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  div_op;
    logic [31:0] rdata1, rdata2;
    logic        ready;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    div_iterative_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .div_op (div_op),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .ready  (ready),
        .result (result)
    );

    always #5 clk = ~clk;

    // Starts an op just after a posedge; the next posedge closes cycle 0. Returns the cycle
    // ready was seen in (-1 if never), the result then, and ready pulses over the next 3 cycles.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int pulses);
        div_op = op; rdata1 = a; rdata2 = b; enable = 1'b1;
        lat = -1; res = 'x; pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; res = result; enable = 1'b0;
                end
            end
            if (lat >= 0 && k >= lat + 3) break;
        end
        enable = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat, pulses;
        logic [31:0] res;
        run_op(op, a, b, lat, res, pulses);
        total++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else passed++;
        total++;
        if (res !== exp_res) $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        else passed++;
        total++;
        if (pulses !== 1) $display("FAIL %s ready pulses: got %0d expected 1", name, pulses);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; div_op = '0; rdata1 = '0; rdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_state: got ready=%b result=%h expected ready=0 result=0", ready, result);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd14);
        check_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 33, 32'd2);
    endtask

    task automatic test_signed();
        check_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        check_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        check_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
    endtask

    task automatic test_div_zero();
        check_op("div_by0",  OP_DIV,  32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF);
        check_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF);
        check_op("rem_by0",  OP_REM,  32'h1234_5678, 32'd0, 1, 32'h1234_5678);
        check_op("remu_by0", OP_REMU, 32'h1234_5678, 32'd0, 1, 32'h1234_5678);
    endtask

    task automatic test_overflow();
        check_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000);
        check_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0);
        check_op("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0);
    endtask

    task automatic test_abort();
        int seen;
        div_op = OP_DIVU; rdata1 = 32'd1000; rdata2 = 32'd3; enable = 1'b1;
        seen = 0;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 10) enable = 1'b0;
            if (ready) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_no_ready: got %0d pulses expected 0", seen);
        else passed++;
        check_op("after_abort_9_3", OP_DIVU, 32'd9, 32'd3, 33, 32'd3);
    endtask

    task automatic test_mid_reset();
        int seen;
        div_op = OP_DIVU; rdata1 = 32'd1000; rdata2 = 32'd3; enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0 || result !== 32'h0)
            $display("FAIL mid_reset: got ready=%b result=%h expected ready=0 result=0", ready, result);
        else passed++;
        rst = 1'b1; enable = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL mid_reset_no_ready: got %0d pulses expected 0", seen);
        else passed++;
        check_op("after_reset_idle", OP_DIVU, 32'd81, 32'd9, 33, 32'd9);
    endtask

    task automatic test_back_to_back();
        int first, second, pulses;
        logic [31:0] r1, r2;
        div_op = OP_DIVU; rdata1 = 32'd50; rdata2 = 32'd5; enable = 1'b1;
        first = -1; second = -1; pulses = 0; r1 = 'x; r2 = 'x;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                pulses++;
                if (first < 0) begin
                    first = k; r1 = result;
                    rdata1 = 32'd81; rdata2 = 32'd9;
                end else if (second < 0) begin
                    second = k; r2 = result; enable = 1'b0;
                end
            end
            if (second >= 0 && k >= second + 3) break;
        end
        enable = 1'b0;
        total++;
        if (first !== 33) $display("FAIL b2b_first_latency: got %0d expected 33", first);
        else passed++;
        total++;
        if (second - first !== 34) $display("FAIL b2b_gap: got %0d expected 34", second - first);
        else passed++;
        total++;
        if (r1 !== 32'd10 || r2 !== 32'd9)
            $display("FAIL b2b_results: got %0d,%0d expected 10,9", r1, r2);
        else passed++;
        total++;
        if (pulses !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_iterative_unit.md
Name: div_iterative_unit

Overview:
- Multi-cycle RV32M divider: the responder side of the execute stage's division handshake (enable in, ready/result out).
- Implements DIV, DIVU, REM and REMU with radix-2 restoring division, one quotient bit per cycle.
- The execute stage holds enable high and stalls until ready pulses. It then writes result to the register file.
- Divide-by-zero and signed overflow are resolved in a short path that bypasses the iterations.

Parameters:
- XLEN, 32, operand/result width; the iteration counter is $clog2(XLEN) bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- enable  input  1  request level; held high by the initiator for the whole operation
- div_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rdata1  input  XLEN  dividend
- rdata2  input  XLEN  divisor
- ready  output  1  one-cycle completion pulse
- result  output  XLEN  quotient or remainder; valid only while ready=1

Behaviour:
- Reset (rst=0 at a clk edge) applies at any time, including mid-operation:
  - state returns to IDLE, ready=0, result=0, internal registers cleared.
  - The aborted operation produces no ready.
- States are IDLE, BUSY and DONE. ready is registered and is 1 only in DONE.
- IDLE:
  - If enable=1, latch div_op, rdata1 and rdata2.
  - signed = (div_op[0]==0).
  - Compute magnitudes (two's-complement negate when signed and MSB set).
  - qneg = signed & (a[XLEN-1]^b[XLEN-1]); rneg = signed & a[XLEN-1].
  - If divisor==0: go to DONE with result = all ones (DIV/DIVU) or rdata1 (REM/REMU).
  - Else if signed, dividend=0x80000000 and divisor=0xFFFFFFFF: go to DONE with result = 0x80000000 (DIV) or 0 (REM).
  - Otherwise clear the remainder, load the quotient with |dividend|, set the counter to XLEN-1 and go to BUSY.
  - If enable=0, stay in IDLE.
- BUSY: one iteration per cycle.
  - Shift {rem,quo} left by 1 and compute trial = rem - |divisor| (XLEN+1 bits).
  - If trial is non-negative, rem=trial and quo[0]=1; else quo[0]=0.
  - The counter decrements. After the iteration with counter==0, go to DONE.
  - On entering DONE, result = quo (negated if qneg) for DIV/DIVU, or rem (negated if rneg) for REM/REMU.
- Abort: if enable=0 in any BUSY cycle (pipeline clear or downstream stall), go to IDLE immediately, with no ready and result unchanged. A later enable starts a completely new operation from fresh operands.
- DONE:
  - ready=1 for exactly one cycle and result holds.
  - The next state is always IDLE, regardless of enable.
  - The operation is not re-reported.
- Latency (cycle 0 = first cycle IDLE samples enable=1):
  - Normal operation: ready=1 in cycle XLEN+1 (33).
  - Zero divisor or overflow: ready=1 in cycle 1.
- Back-to-back: enable high in the cycle after ready (a new instruction) is sampled in IDLE and starts cycle 0 of a new operation. There is therefore one IDLE cycle between operations.
- Operand changes on rdata1/rdata2/div_op while in BUSY are ignored; only the values latched in IDLE are used.
- result retains its last value outside DONE. Consumers must qualify it with ready.

Test Plan:
1. DIVU 100/7, enable held → ready=1 only in cycle 33, result=14. Repeat as REMU → result=2.
2. DIV -7/2 → result=0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1. All with ready in cycle 33.
3. Zero divisor, rdata1=0x12345678 → ready in cycle 1, with:
   - DIV and DIVU → result 0xFFFFFFFF.
   - REM and REMU → result 0x12345678.
4. Signed overflow (0x80000000 / 0xFFFFFFFF) → ready in cycle 1, DIV → 0x80000000, REM → 0. DIVU of the same operands takes 33 cycles, result=0.
5. Abort and reset:
   - DIVU 1000/3: drop enable at cycle 10 → no ready pulse.
   - Reassert enable with DIVU 9/3 → ready 33 cycles after reassertion, result=3.
   - Separately, rst=0 at cycle 20 → ready=0, result=0, state IDLE.
6. Back-to-back: DIVU 50/5, enable kept high across the ready cycle with new operands DIVU 81/9 → second ready 34 cycles after the first, results 10 then 9, with exactly one ready per operation.
